// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: state encoding and helpers shared by the UART control blocks
package uart_ctrl_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LAUNCH = 2'd1,
    ARB_WAIT   = 2'd2
  } arb_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: first set request searching upward from last+1, wrapping modulo N
module uart_rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int N = 4,
  localparam int W = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] idx
);
  logic [W-1:0] w_cand;
  assign any = |req;
  always_comb begin
    idx = '0;
    w_cand = '0;
    for (int k = N; k >= 1; k--) begin
      w_cand = W'((int'(last) + k) % N);
      if (req[w_cand]) idx = w_cand;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between NUM_REQ byte producers
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_CLKS = 12 * CLKS_PER_BIT,
  localparam int GW = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_bytes,
  output logic [NUM_REQ-1:0]   o_req_ack,
  output logic [NUM_REQ-1:0]   o_req_done,
  output logic                 o_tx_dv,
  output logic [7:0]           o_tx_byte,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic [GW-1:0]        o_grant_id,
  output logic                 o_timeout
);
  localparam int CW = (TIMEOUT_CLKS > 1) ? clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CLKS - 1);
  arb_state_t           r_state;
  logic [GW-1:0]        r_last;
  logic [CW-1:0]        r_cnt;
  logic [NUM_REQ-1:0]   r_req_ack;
  logic [NUM_REQ-1:0]   r_req_done;
  logic                 r_tx_dv;
  logic [7:0]           r_tx_byte;
  logic                 r_busy;
  logic [GW-1:0]        r_grant;
  logic                 r_timeout;
  logic                 w_any;
  logic [GW-1:0]        w_idx;
  logic [NUM_REQ-1:0]   w_onehot;
  uart_rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (i_req_valid),
    .last (r_last),
    .any  (w_any),
    .idx  (w_idx)
  );
  assign w_onehot   = NUM_REQ'(1) << w_idx;
  assign o_req_ack  = r_req_ack;
  assign o_req_done = r_req_done;
  assign o_tx_dv    = r_tx_dv;
  assign o_tx_byte  = r_tx_byte;
  assign o_busy     = r_busy;
  assign o_grant_id = r_grant;
  assign o_timeout  = r_timeout;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ARB_IDLE;
      r_last     <= GW'(NUM_REQ - 1);
      r_cnt      <= '0;
      r_req_ack  <= '0;
      r_req_done <= '0;
      r_tx_dv    <= 1'b0;
      r_tx_byte  <= '0;
      r_busy     <= 1'b0;
      r_grant    <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_tx_dv    <= 1'b0;
      r_req_ack  <= '0;
      r_req_done <= '0;
      r_timeout  <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_any && !i_tx_active) begin
            r_state   <= ARB_LAUNCH;
            r_tx_dv   <= 1'b1;
            r_req_ack <= w_onehot;
            r_busy    <= 1'b1;
            r_grant   <= w_idx;
            r_tx_byte <= i_req_bytes[8*w_idx +: 8];
          end
        end
        ARB_LAUNCH: begin
          r_state <= ARB_WAIT;
          r_cnt   <= '0;
        end
        ARB_WAIT: begin
          r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
          if (i_tx_done) begin
            r_req_done <= NUM_REQ'(1) << r_grant;
            r_last     <= r_grant;
            r_busy     <= 1'b0;
            r_state    <= ARB_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_timeout <= 1'b1;
            r_last    <= r_grant;
            r_busy    <= 1'b0;
            r_state   <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` instance between `NUM_REQ` byte producers. It accepts a byte from one requester and launches it with a single-cycle `o_tx_dv` pulse. It then holds off further launches until `uart_tx` reports `o_tx_done` or a watchdog expires. It sits between the producer logic and `uart_tx`, in front of the loopback/serial path.

## Interface
- `NUM_REQ`, default 4: number of requesters, 1..16.
- `CLKS_PER_BIT`, default 87: must match the `uart_tx` instance.
- `TIMEOUT_CLKS`, default `12*CLKS_PER_BIT`: cycles allowed in WAIT before abort.
- `i_clock`  in  1: single clock.
- `i_reset`  in  1: synchronous, active-high reset.
- `i_req_valid`  in  NUM_REQ: per-requester byte-pending flag.
- `i_req_bytes`  in  8*NUM_REQ: requester k's byte is at [8k+7:8k].
- `o_req_ack`  out  NUM_REQ: one-hot, 1-cycle pulse when the granted byte is taken.
- `o_req_done`  out  NUM_REQ: one-hot, 1-cycle pulse when the owner's byte has finished transmitting.
- `o_tx_dv`  out  1: connects to `uart_tx.i_tx_dv`.
- `o_tx_byte`  out  8: connects to `uart_tx.i_tx_byte`.
- `i_tx_active`  in  1: from `uart_tx.o_tx_active`.
- `i_tx_done`  in  1: from `uart_tx.o_tx_done`.
- `o_busy`  out  1: high in LAUNCH and WAIT.
- `o_grant_id`  out  max(1,clog2(NUM_REQ)): current or last owner.
- `o_timeout`  out  1: 1-cycle pulse when the watchdog aborts a transfer.

## Operation
- States:
  - IDLE: waiting for a request.
  - LAUNCH: one cycle; `o_tx_dv`=1 and `o_tx_byte` driven.
  - WAIT: counting cycles until done or timeout.
- IDLE -> LAUNCH when `|i_req_valid` and `!i_tx_active`. The winner g is the first set bit searching from `last_grant+1` modulo NUM_REQ.
  - In the same transition, `i_req_bytes[g]` is registered into `o_tx_byte` and `o_grant_id`.
- LAUNCH -> WAIT unconditionally. The watchdog counter clears to 0.
- WAIT: the counter increments each cycle.
  - If `i_tx_done`=1: pulse `o_req_done[g]`, set `last_grant`=g, go to IDLE.
  - Else if counter == TIMEOUT_CLKS-1: pulse `o_timeout`, set `last_grant`=g, go to IDLE; `o_req_done` is not pulsed.
- `i_tx_done` and timeout in the same cycle: done wins and `o_timeout` stays 0.
- `i_req_valid` is sampled only in IDLE. A requester may drop valid before its ack; a requester without an ack must keep its byte stable.
- The watchdog counter is clog2(TIMEOUT_CLKS) bits wide and saturates; it never wraps.
- `i_tx_done` seen outside WAIT is ignored.
- Reset values:
  - State IDLE; `last_grant`=NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0: `o_tx_dv`, `o_tx_byte`, `o_req_ack`, `o_req_done`, `o_busy`, `o_grant_id`, `o_timeout`.
- Reset mid-transfer:
  - The in-flight byte is abandoned and no done is reported.
  - `uart_tx` has no reset, so the next launch waits for `i_tx_active`=0.

## Timing
- All outputs are registered.
- Request seen in IDLE at cycle T:
  - `o_req_ack[g]`, `o_tx_dv`, `o_busy` and the updated `o_grant_id` are high at T+1.
  - State is WAIT from T+2.
- `o_tx_dv` is high for exactly one cycle per launch. `o_tx_byte` holds its value until the next launch.
- `i_tx_done` at cycle D:
  - `o_req_done[g]` pulses at D+1, and `o_busy` is 0 at D+1.
  - The earliest next `o_tx_dv` is D+2, provided `i_tx_active`=0 at D+1.
- Timeout: `o_timeout` pulses TIMEOUT_CLKS+1 cycles after the LAUNCH cycle.
- Back-to-back bytes with the default parameters take 10*CLKS_PER_BIT plus 3 arbitration cycles each.

## Structure
- Shared package `uart_ctrl_pkg`:
  - State encoding localparams ARB_IDLE=2'd0, ARB_LAUNCH=2'd1, ARB_WAIT=2'd2.
  - A `clog2` function, reused by other UART control blocks.
- One combinational sub-module `uart_rr_pick` (parameter N):
  - Inputs `req[N-1:0]` and `last[clog2 N-1:0]`.
  - Outputs `any` and `idx`.
- Top level: `uart_tx_arbiter` plus `uart_tx` plus `uart_rx` in the loopback testbench.

## Test plan
- Single request: reset, then `i_req_valid`=4'b0001 with byte 0xA5 -> ack[0] and `o_tx_dv` at T+1; `o_rx_byte`=0xA5 in loopback; `o_req_done[0]` one cycle after `i_tx_done`.
- Fairness: all four valid continuously with bytes 0x10/0x21/0x32/0x43 -> grant order 0,1,2,3,0; RX sequence 0x10,0x21,0x32,0x43,0x10.
- Timeout: bench models `uart_tx` that never asserts done, with `TIMEOUT_CLKS`=50 -> `o_timeout` pulses 51 cycles after LAUNCH, no `o_req_done`; next requester granted afterward.
- Done/timeout collision: force `i_tx_done` on the timeout cycle -> `o_req_done[g]`=1 and `o_timeout`=0.
- Reset mid-WAIT: assert `i_reset` at bit 4 of byte 0x5A -> all outputs 0 next cycle; no new `o_tx_dv` until `i_tx_active` falls; then requester 0 is granted first.
- Request withdrawn: valid[2] pulsed for 1 cycle while in WAIT -> no ack[2], no launch.
